// File: rtl/sram_arb_pkg.sv
// Shared state encoding and constants for the fetch/LSU SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LSU_ACC = 2'd1,
    IF_ACC  = 2'd2,
    DONE    = 2'd3
  } sram_arb_state_e;

  localparam int unsigned SRAM_ARB_TIMEOUT_DEF = 255;
  localparam logic [3:0]  SRAM_ARB_FULL_BMASK  = 4'hF;

endpackage

// File: rtl/sram_arbiter.sv
// Serialises LSU and fetch accesses to the shared single-port SRAM for one
// pipeline cycle (LSU first) and freezes the pipeline until both complete.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned TIMEOUT = SRAM_ARB_TIMEOUT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  input  logic              i_lsu_req,
  input  logic              i_lsu_we,
  input  logic [31:0]       i_lsu_addr,
  input  logic [31:0]       i_lsu_wdata,
  input  logic [3:0]        i_lsu_bmask,
  output logic [31:0]       o_if_rdata,
  output logic [31:0]       o_lsu_rdata,
  output logic              o_sram_stall,
  output logic              o_err,
  output logic              o_sram_req,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [31:0]       o_sram_wdata,
  output logic [3:0]        o_sram_bmask,
  input  logic [31:0]       i_sram_rdata,
  input  logic              i_sram_ack
);

  localparam int unsigned CNT_W = (TIMEOUT > 256) ? $clog2(TIMEOUT) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sram_arb_state_e   state;
  sram_arb_state_e   state_next;
  logic              stall_c;
  logic              acc_st;
  logic              timeout_c;
  logic              acc_end;
  logic              pend_if;
  logic [ADDR_W-1:0] if_addr_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       lsu_hold;
  logic [31:0]       if_hold;
  logic              unused_addr;

  // Only the word-address slice of the byte addresses is used.
  assign unused_addr = ^{i_if_addr, i_lsu_addr};

  assign acc_st    = (state == LSU_ACC) || (state == IF_ACC);
  assign timeout_c = acc_st && !i_sram_ack && (wait_cnt == CNT_LAST);
  assign acc_end   = acc_st && (i_sram_ack || timeout_c);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and Mealy stall; stall rises in the request's first cycle.
  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        stall_c = i_lsu_req || i_if_req;
        if (i_lsu_req)     state_next = LSU_ACC;
        else if (i_if_req) state_next = IF_ACC;
      end
      LSU_ACC: begin
        stall_c = 1'b1;
        if (acc_end) state_next = pend_if ? IF_ACC : DONE;
      end
      IF_ACC: begin
        stall_c = 1'b1;
        if (acc_end) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_sram_stall = !i_rst && stall_c;

  // Pending fetch, wait counter, hold registers and the error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_if   <= 1'b0;
      if_addr_q <= '0;
      wait_cnt  <= '0;
      lsu_hold  <= '0;
      if_hold   <= '0;
      o_err     <= 1'b0;
    end else begin
      o_err <= timeout_c;
      if (state == IDLE) begin
        pend_if   <= i_if_req;
        if_addr_q <= i_if_addr[ADDR_W+1:2];
      end
      if (acc_st && (state_next == state)) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                 wait_cnt <= '0;
      if ((state == LSU_ACC) && acc_end) begin
        if (timeout_c)       lsu_hold <= '0;
        else if (!o_sram_we) lsu_hold <= i_sram_rdata;
      end
      if ((state == IF_ACC) && acc_end) begin
        if_hold <= timeout_c ? 32'h0 : i_sram_rdata;
      end
    end
  end

  // SRAM strobe and payload track the state being entered, so req stays
  // high without a gap across the LSU-to-fetch handover.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sram_req   <= 1'b0;
      o_sram_we    <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_wdata <= '0;
      o_sram_bmask <= '0;
    end else begin
      case (state_next)
        LSU_ACC: begin
          o_sram_req   <= 1'b1;
          o_sram_we    <= i_lsu_we;
          o_sram_addr  <= i_lsu_addr[ADDR_W+1:2];
          o_sram_wdata <= i_lsu_wdata;
          o_sram_bmask <= i_lsu_bmask;
        end
        IF_ACC: begin
          o_sram_req   <= 1'b1;
          o_sram_we    <= 1'b0;
          o_sram_addr  <= (state == IDLE) ? i_if_addr[ADDR_W+1:2] : if_addr_q;
          o_sram_bmask <= SRAM_ARB_FULL_BMASK;
        end
        default: begin
          o_sram_req <= 1'b0;
          o_sram_we  <= 1'b0;
        end
      endcase
    end
  end

  assign o_if_rdata  = if_hold;
  assign o_lsu_rdata = lsu_hold;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: fetch, load+fetch, store, timeout, reset.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_bmask;
  logic [31:0] if_rdata;
  logic [31:0] lsu_rdata;
  logic        stall;
  logic        err;
  logic        sreq;
  logic        swe;
  logic [17:0] saddr;
  logic [31:0] swdata;
  logic [3:0]  sbmask;
  logic [31:0] srdata;
  logic        sack;

  int n_cmp;
  int n_bad;

  sram_arbiter #(.ADDR_W(18), .TIMEOUT(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_if_req     (if_req),
    .i_if_addr    (if_addr),
    .i_lsu_req    (lsu_req),
    .i_lsu_we     (lsu_we),
    .i_lsu_addr   (lsu_addr),
    .i_lsu_wdata  (lsu_wdata),
    .i_lsu_bmask  (lsu_bmask),
    .o_if_rdata   (if_rdata),
    .o_lsu_rdata  (lsu_rdata),
    .o_sram_stall (stall),
    .o_err        (err),
    .o_sram_req   (sreq),
    .o_sram_we    (swe),
    .o_sram_addr  (saddr),
    .o_sram_wdata (swdata),
    .o_sram_bmask (sbmask),
    .i_sram_rdata (srdata),
    .i_sram_ack   (sack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; lsu_req = 1'b0; lsu_we = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_bmask = '0; srdata = '0; sack = 1'b0;
    #1 rst = 1'b1;

    // Reset state, with requests present to show stall is forced low.
    repeat (2) @(negedge clk);
    if_req = 1'b1; lsu_req = 1'b1; #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(sreq), 32'd0);
    chk("rst_we", 32'(swe), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(saddr), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_lsu_rdata", lsu_rdata, 32'h0);
    if_req = 1'b0; lsu_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_stall", 32'(stall), 32'd0);

    // Fetch only, ack latency 1.
    @(negedge clk); if_req = 1'b1; if_addr = 32'h40; #1;
    chk("f_idle_stall", 32'(stall), 32'd1);
    chk("f_idle_req", 32'(sreq), 32'd0);
    @(negedge clk); #1;
    chk("f_acc_req", 32'(sreq), 32'd1);
    chk("f_acc_addr", 32'(saddr), 32'd16);
    chk("f_acc_we", 32'(swe), 32'd0);
    chk("f_acc_bmask", 32'(sbmask), 32'hF);
    chk("f_acc_stall", 32'(stall), 32'd1);
    sack = 1'b1; srdata = 32'h0000_0013;
    @(negedge clk); sack = 1'b0; srdata = '0; if_req = 1'b0; #1;
    chk("f_done_stall", 32'(stall), 32'd0);
    chk("f_done_req", 32'(sreq), 32'd0);
    chk("f_done_rdata", if_rdata, 32'h13);
    @(negedge clk); #1;
    chk("f_idle2_stall", 32'(stall), 32'd0);
    chk("f_idle2_rdata", if_rdata, 32'h13);

    // Load + fetch in one cycle, ack latency 2 each.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100; if_req = 1'b1; if_addr = 32'h8; #1;
    chk("lf_idle_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("lf_lsu1_req", 32'(sreq), 32'd1);
    chk("lf_lsu1_addr", 32'(saddr), 32'd64);
    chk("lf_lsu1_we", 32'(swe), 32'd0);
    chk("lf_lsu1_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("lf_lsu2_addr", 32'(saddr), 32'd64);
    chk("lf_lsu2_stall", 32'(stall), 32'd1);
    sack = 1'b1; srdata = 32'hCAFE_0001;
    @(negedge clk); sack = 1'b0; srdata = '0; #1;
    chk("lf_if1_req", 32'(sreq), 32'd1);
    chk("lf_if1_addr", 32'(saddr), 32'd2);
    chk("lf_if1_stall", 32'(stall), 32'd1);
    chk("lf_if1_lsu_rdata", lsu_rdata, 32'hCAFE_0001);
    @(negedge clk); #1;
    chk("lf_if2_stall", 32'(stall), 32'd1);
    sack = 1'b1; srdata = 32'h1234_5678;
    @(negedge clk); sack = 1'b0; srdata = '0; lsu_req = 1'b0; if_req = 1'b0; #1;
    chk("lf_done_stall", 32'(stall), 32'd0);
    chk("lf_done_req", 32'(sreq), 32'd0);
    chk("lf_done_if_rdata", if_rdata, 32'h1234_5678);
    chk("lf_done_lsu_rdata", lsu_rdata, 32'hCAFE_0001);

    // Store, no fetch: LSU hold register must not change.
    @(negedge clk);
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h200; lsu_wdata = 32'hDEAD_BEEF;
    lsu_bmask = 4'b0011; #1;
    chk("st_idle_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("st_req", 32'(sreq), 32'd1);
    chk("st_we", 32'(swe), 32'd1);
    chk("st_bmask", 32'(sbmask), 32'h3);
    chk("st_wdata", swdata, 32'hDEAD_BEEF);
    chk("st_addr", 32'(saddr), 32'd128);
    sack = 1'b1; srdata = 32'h5555_5555;
    @(negedge clk); sack = 1'b0; srdata = '0; lsu_req = 1'b0; lsu_we = 1'b0; #1;
    chk("st_done_stall", 32'(stall), 32'd0);
    chk("st_done_we", 32'(swe), 32'd0);
    chk("st_done_lsu_rdata", lsu_rdata, 32'hCAFE_0001);

    // Fetch with no ack: abort after 4 wait cycles (TIMEOUT=4).
    @(negedge clk); if_req = 1'b1; if_addr = 32'h80; #1;
    chk("to_idle_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("to_w1_err", 32'(err), 32'd0);
    chk("to_w1_addr", 32'(saddr), 32'd32);
    @(negedge clk); #1;
    chk("to_w2_err", 32'(err), 32'd0);
    @(negedge clk); #1;
    chk("to_w3_err", 32'(err), 32'd0);
    @(negedge clk); #1;
    chk("to_w4_req", 32'(sreq), 32'd1);
    chk("to_w4_stall", 32'(stall), 32'd1);
    @(negedge clk); if_req = 1'b0; #1;
    chk("to_done_err", 32'(err), 32'd1);
    chk("to_done_stall", 32'(stall), 32'd0);
    chk("to_done_req", 32'(sreq), 32'd0);
    chk("to_done_if_rdata", if_rdata, 32'h0);
    @(negedge clk); #1;
    chk("to_idle2_err", 32'(err), 32'd0);
    chk("to_idle2_stall", 32'(stall), 32'd0);

    // Reset during LSU_ACC drops req and stall at once.
    @(negedge clk); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h300; #1;
    @(negedge clk); #1;
    chk("rr_acc_req", 32'(sreq), 32'd1);
    rst = 1'b1; #1;
    chk("rr_req", 32'(sreq), 32'd0);
    chk("rr_stall", 32'(stall), 32'd0);
    chk("rr_lsu_rdata", lsu_rdata, 32'h0);
    lsu_req = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Spurious ack in IDLE is ignored.
    @(negedge clk); sack = 1'b1; srdata = 32'hFFFF_FFFF; #1;
    chk("sp_stall", 32'(stall), 32'd0);
    @(negedge clk); sack = 1'b0; srdata = '0; #1;
    chk("sp_req", 32'(sreq), 32'd0);
    chk("sp_err", 32'(err), 32'd0);
    chk("sp_if_rdata", if_rdata, 32'h0);
    chk("sp_lsu_rdata", lsu_rdata, 32'h0);

    // FSM is back in IDLE: a fresh fetch completes normally.
    @(negedge clk); if_req = 1'b1; if_addr = 32'h4; #1;
    chk("pf_idle_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    chk("pf_acc_addr", 32'(saddr), 32'd1);
    sack = 1'b1; srdata = 32'h0000_00A5;
    @(negedge clk); sack = 1'b0; srdata = '0; if_req = 1'b0; #1;
    chk("pf_done_rdata", if_rdata, 32'hA5);
    chk("pf_done_lsu_rdata", lsu_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
